aemb2_dwbarb: RTL and testbench

Two-master Wishbone arbiter for the AEMB2 data bus. It shares one external DWB port between master 0 (the core data interface) and master 1 (a secondary agent such as a DMA or debug port). Arbitration is round-robin, and ownership persists for a whole locked bus cycle. A bus-watchdog terminates stalled transfers with an error pulse. The block sits between the core data interface and the system Wishbone fabric.

---
 rtl/aemb2_dwbarb.sv | 163 ++++++++++++++++
 tb/tb_aemb2_dwbarb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aemb2_dwbarb.sv
// aemb2_dwbarb: two-master Wishbone arbiter for the AEMB2 data bus.
// Shares one external DWB port between master 0 (core data interface) and
// master 1 (secondary agent). Grants are round-robin between simultaneous
// requesters, and a grant is held until the owner drops cyc. A watchdog
// ends a stalled strobe with an ack+err pulse to the owner.
//
// Ports:
//   gclk, grst             clock, synchronous active-high reset
//   m0_* / m1_*            master-side Wishbone signals (adr/sel/stb/cyc/wre/tag/dat in,
//                          dat/ack/err out)
//   dwb_*                  shared slave-side Wishbone port
//   arb_gnt_o              one-hot grant {m1, m0}
module aemb2_dwbarb #(
  parameter int AEMB_DWB = 32,
  parameter int AEMB_TMO = 8
) (
  input  logic                gclk,
  input  logic                grst,
  // master 0
  input  logic [AEMB_DWB-1:2] m0_adr_i,
  input  logic [3:0]          m0_sel_i,
  input  logic                m0_stb_i,
  input  logic                m0_cyc_i,
  input  logic                m0_wre_i,
  input  logic                m0_tag_i,
  input  logic [31:0]         m0_dat_i,
  output logic [31:0]         m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  // master 1
  input  logic [AEMB_DWB-1:2] m1_adr_i,
  input  logic [3:0]          m1_sel_i,
  input  logic                m1_stb_i,
  input  logic                m1_cyc_i,
  input  logic                m1_wre_i,
  input  logic                m1_tag_i,
  input  logic [31:0]         m1_dat_i,
  output logic [31:0]         m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  // shared bus
  output logic [AEMB_DWB-1:2] dwb_adr_o,
  output logic [3:0]          dwb_sel_o,
  output logic                dwb_stb_o,
  output logic                dwb_cyc_o,
  output logic                dwb_wre_o,
  output logic                dwb_tag_o,
  output logic [31:0]         dwb_dat_o,
  input  logic [31:0]         dwb_dat_i,
  input  logic                dwb_ack_i,
  output logic [1:0]          arb_gnt_o
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  // Count value during the last unacknowledged strobe cycle before timeout.
  localparam logic [AEMB_TMO-1:0] TmoLast = {{(AEMB_TMO-1){1'b1}}, 1'b0};
  localparam logic [AEMB_TMO-1:0] TmoOne  = {{(AEMB_TMO-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic                last_q, last_d;  // last owner: 0 = m0, 1 = m1
  logic [AEMB_TMO-1:0] tmo_q, tmo_d;

  logic req0, req1;
  logic own0, own1;
  logic tmo_full, tmo_fire;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // State register
  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;  // m1 "last" so m0 wins the first contested grant
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (req0 && req1) state_d = last_q ? StOwn0 : StOwn1;
        else if (req0)    state_d = StOwn0;
        else if (req1)    state_d = StOwn1;
      end
      StOwn0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = req1 ? StOwn1 : StIdle;
        end
      end
      StOwn1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = req0 ? StOwn0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog: the count reaches all-ones on the timeout cycle, then the
    // all-ones cycle suppresses stb once and restarts the count.
    tmo_d = tmo_q;
    if (state_q == StIdle || state_d != state_q || dwb_ack_i || tmo_full) begin
      tmo_d = '0;
    end else if (dwb_stb_o) begin
      tmo_d = tmo_q + TmoOne;
    end
  end

  // Output logic; reset gates the bus in the reset cycle itself so a pending
  // slave ack is never forwarded.
  always_comb begin
    own0     = !grst && (state_q == StOwn0);
    own1     = !grst && (state_q == StOwn1);
    tmo_full = &tmo_q;

    dwb_adr_o = '0;
    dwb_sel_o = '0;
    dwb_stb_o = 1'b0;
    dwb_cyc_o = 1'b0;
    dwb_wre_o = 1'b0;
    dwb_tag_o = 1'b0;
    dwb_dat_o = '0;
    if (own0) begin
      dwb_adr_o = m0_adr_i;
      dwb_sel_o = m0_sel_i;
      dwb_stb_o = m0_stb_i & ~tmo_full;
      dwb_cyc_o = m0_cyc_i;
      dwb_wre_o = m0_wre_i;
      dwb_tag_o = m0_tag_i;
      dwb_dat_o = m0_dat_i;
    end else if (own1) begin
      dwb_adr_o = m1_adr_i;
      dwb_sel_o = m1_sel_i;
      dwb_stb_o = m1_stb_i & ~tmo_full;
      dwb_cyc_o = m1_cyc_i;
      dwb_wre_o = m1_wre_i;
      dwb_tag_o = m1_tag_i;
      dwb_dat_o = m1_dat_i;
    end

    // A real ack in the timeout cycle suppresses the error.
    tmo_fire = dwb_stb_o & ~dwb_ack_i & (tmo_q == TmoLast);

    m0_ack_o  = own0 & ((dwb_ack_i & m0_stb_i) | tmo_fire);
    m1_ack_o  = own1 & ((dwb_ack_i & m1_stb_i) | tmo_fire);
    m0_err_o  = own0 & tmo_fire;
    m1_err_o  = own1 & tmo_fire;
    m0_dat_o  = dwb_dat_i;
    m1_dat_o  = dwb_dat_i;
    arb_gnt_o = {own1, own0};
  end

endmodule

// File: tb/tb_aemb2_dwbarb.sv
// Directed self-checking bench for aemb2_dwbarb.
module tb_aemb2_dwbarb;

  logic        gclk = 1'b0;
  logic        grst;
  logic [31:2] m0_adr, m1_adr, dwb_adr_o;
  logic [3:0]  m0_sel, m1_sel, dwb_sel_o;
  logic        m0_stb, m0_cyc, m0_wre, m0_tag;
  logic        m1_stb, m1_cyc, m1_wre, m1_tag;
  logic [31:0] m0_dat, m1_dat, m0_dat_o, m1_dat_o, dwb_dat_o, dwb_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        dwb_stb_o, dwb_cyc_o, dwb_wre_o, dwb_tag_o, dwb_ack_i;
  logic [1:0]  arb_gnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic any_ack;

  always #5 gclk = ~gclk;

  aemb2_dwbarb #(.AEMB_DWB(32), .AEMB_TMO(8)) dut (
    .gclk      (gclk),
    .grst      (grst),
    .m0_adr_i  (m0_adr),
    .m0_sel_i  (m0_sel),
    .m0_stb_i  (m0_stb),
    .m0_cyc_i  (m0_cyc),
    .m0_wre_i  (m0_wre),
    .m0_tag_i  (m0_tag),
    .m0_dat_i  (m0_dat),
    .m0_dat_o  (m0_dat_o),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m1_adr_i  (m1_adr),
    .m1_sel_i  (m1_sel),
    .m1_stb_i  (m1_stb),
    .m1_cyc_i  (m1_cyc),
    .m1_wre_i  (m1_wre),
    .m1_tag_i  (m1_tag),
    .m1_dat_i  (m1_dat),
    .m1_dat_o  (m1_dat_o),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .dwb_adr_o (dwb_adr_o),
    .dwb_sel_o (dwb_sel_o),
    .dwb_stb_o (dwb_stb_o),
    .dwb_cyc_o (dwb_cyc_o),
    .dwb_wre_o (dwb_wre_o),
    .dwb_tag_o (dwb_tag_o),
    .dwb_dat_o (dwb_dat_o),
    .dwb_dat_i (dwb_dat_i),
    .dwb_ack_i (dwb_ack_i),
    .arb_gnt_o (arb_gnt_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drop_all();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
  endtask

  initial begin
    grst = 1'b1;
    m0_adr = '0; m0_sel = '0; m0_wre = 1'b0; m0_tag = 1'b0; m0_dat = '0;
    m1_adr = '0; m1_sel = '0; m1_wre = 1'b0; m1_tag = 1'b0; m1_dat = '0;
    drop_all();
    dwb_ack_i = 1'b0; dwb_dat_i = '0;

    // Reset state
    step(); step(); settle();
    check_eq("rst_gnt", 32'(arb_gnt_o), 32'd0);
    check_eq("rst_cyc", 32'(dwb_cyc_o), 32'd0);
    check_eq("rst_stb", 32'(dwb_stb_o), 32'd0);
    check_eq("rst_ack0", 32'(m0_ack_o), 32'd0);
    grst = 1'b0;
    step();

    // Stray ack in IDLE, idle bus driven to zero
    m0_adr = 30'h3ff; m0_sel = 4'hf; dwb_ack_i = 1'b1;
    settle();
    check_eq("stray_ack0", 32'(m0_ack_o), 32'd0);
    check_eq("stray_ack1", 32'(m1_ack_o), 32'd0);
    check_eq("idle_adr", 32'(dwb_adr_o), 32'd0);
    check_eq("idle_sel", 32'(dwb_sel_o), 32'd0);
    step(); dwb_ack_i = 1'b0; settle();
    check_eq("stray_gnt", 32'(arb_gnt_o), 32'd0);

    // Simultaneous requests from reset: m0 first, then handover to m1
    m0_adr = 30'h10; m1_adr = 30'h20;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    settle();
    check_eq("sim_gnt_latency", 32'(arb_gnt_o), 32'd0);
    step(); settle();
    check_eq("sim_gnt_m0", 32'(arb_gnt_o), 32'd1);
    check_eq("sim_adr_m0", 32'(dwb_adr_o), 32'h10);
    dwb_ack_i = 1'b1; dwb_dat_i = 32'h1111_0000; settle();
    check_eq("sim_ack0", 32'(m0_ack_o), 32'd1);
    check_eq("sim_ack1_blocked", 32'(m1_ack_o), 32'd0);
    check_eq("sim_dat0", m0_dat_o, 32'h1111_0000);
    step(); dwb_ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; settle();
    check_eq("drop_gnt_held", 32'(arb_gnt_o), 32'd1);
    check_eq("drop_cyc", 32'(dwb_cyc_o), 32'd0);
    step(); settle();
    check_eq("handover_gnt", 32'(arb_gnt_o), 32'd2);
    check_eq("handover_cyc", 32'(dwb_cyc_o), 32'd1);
    check_eq("handover_adr", 32'(dwb_adr_o), 32'h20);
    dwb_ack_i = 1'b1; settle();
    check_eq("m1_ack", 32'(m1_ack_o), 32'd1);
    check_eq("m0_ack_blocked", 32'(m0_ack_o), 32'd0);
    step(); dwb_ack_i = 1'b0; drop_all(); step(); settle();
    check_eq("back_idle", 32'(arb_gnt_o), 32'd0);

    // m1 was last owner, so m0 wins; m0 then holds a locked 4-transfer cycle
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step(); settle();
    check_eq("rr_m1_last", 32'(arb_gnt_o), 32'd1);
    dwb_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("lock_gnt", 32'(arb_gnt_o), 32'd1);
      check_eq("lock_ack0", 32'(m0_ack_o), 32'd1);
      check_eq("lock_ack1", 32'(m1_ack_o), 32'd0);
      step();
    end
    dwb_ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; settle();
    check_eq("lock_end_gnt", 32'(arb_gnt_o), 32'd1);
    step(); settle();
    check_eq("lock_then_m1", 32'(arb_gnt_o), 32'd2);
    drop_all(); step();

    // Single master read, slave acks after 2 cycles
    m0_adr = 30'h100; m0_sel = 4'h3; m0_cyc = 1'b1; m0_stb = 1'b1;
    step(); settle();
    check_eq("rd_gnt", 32'(arb_gnt_o), 32'd1);
    check_eq("rd_adr", 32'(dwb_adr_o), 32'h100);
    check_eq("rd_sel", 32'(dwb_sel_o), 32'h3);
    check_eq("rd_stb", 32'(dwb_stb_o), 32'd1);
    check_eq("rd_wait_ack", 32'(m0_ack_o), 32'd0);
    step(); settle();
    check_eq("rd_wait_ack2", 32'(m0_ack_o), 32'd0);
    step(); dwb_ack_i = 1'b1; dwb_dat_i = 32'hdead_beef; settle();
    check_eq("rd_ack", 32'(m0_ack_o), 32'd1);
    check_eq("rd_dat", m0_dat_o, 32'hdead_beef);
    check_eq("rd_dat1", m1_dat_o, 32'hdead_beef);
    check_eq("rd_err", 32'(m0_err_o), 32'd0);
    check_eq("rd_ack1", 32'(m1_ack_o), 32'd0);
    step(); dwb_ack_i = 1'b0; drop_all(); settle();
    check_eq("rd_ack_once", 32'(m0_ack_o), 32'd0);
    step();

    // m0 was last owner: contested grant goes to m1
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step(); settle();
    check_eq("rr_m0_last", 32'(arb_gnt_o), 32'd2);
    drop_all(); step(); settle();
    check_eq("idle_again", 32'(arb_gnt_o), 32'd0);

    // Watchdog: slave never acks
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();  // strobe cycle 1
    any_ack = 1'b0;
    for (int i = 1; i < 255; i++) begin
      settle(); any_ack = any_ack | m0_ack_o | m0_err_o; step();
    end
    check_eq("tmo_no_early_ack", 32'(any_ack), 32'd0);
    settle();
    check_eq("tmo_ack", 32'(m0_ack_o), 32'd1);
    check_eq("tmo_err", 32'(m0_err_o), 32'd1);
    check_eq("tmo_err1", 32'(m1_err_o), 32'd0);
    step(); settle();
    check_eq("tmo_stb_gap", 32'(dwb_stb_o), 32'd0);
    check_eq("tmo_gap_ack", 32'(m0_ack_o), 32'd0);
    check_eq("tmo_keep_gnt", 32'(arb_gnt_o), 32'd1);
    step(); settle();
    check_eq("tmo_restart_stb", 32'(dwb_stb_o), 32'd1);
    any_ack = 1'b0;
    for (int i = 1; i < 255; i++) begin
      settle(); any_ack = any_ack | m0_ack_o | m0_err_o; step();
    end
    check_eq("tmo2_no_early_ack", 32'(any_ack), 32'd0);
    dwb_ack_i = 1'b1; settle();
    check_eq("tmo_real_ack", 32'(m0_ack_o), 32'd1);
    check_eq("tmo_real_ack_err", 32'(m0_err_o), 32'd0);
    step(); dwb_ack_i = 1'b0; settle();
    check_eq("tmo_ack_clears", 32'(dwb_stb_o), 32'd1);
    drop_all(); step(); step();

    // Reset during an m1 write (m0 was last owner before reset)
    m1_adr = 30'h40; m1_dat = 32'hcafe_0001; m1_wre = 1'b1; m1_sel = 4'hf;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step(); settle();
    check_eq("wr_gnt", 32'(arb_gnt_o), 32'd2);
    check_eq("wr_wre", 32'(dwb_wre_o), 32'd1);
    check_eq("wr_dat", dwb_dat_o, 32'hcafe_0001);
    check_eq("wr_adr", 32'(dwb_adr_o), 32'h40);
    grst = 1'b1; dwb_ack_i = 1'b1; settle();
    check_eq("rst_ack_blocked", 32'(m1_ack_o), 32'd0);
    step(); grst = 1'b0; dwb_ack_i = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1; settle();
    check_eq("postrst_cyc", 32'(dwb_cyc_o), 32'd0);
    check_eq("postrst_stb", 32'(dwb_stb_o), 32'd0);
    check_eq("postrst_wre", 32'(dwb_wre_o), 32'd0);
    check_eq("postrst_dat", dwb_dat_o, 32'd0);
    check_eq("postrst_gnt", 32'(arb_gnt_o), 32'd0);
    step(); settle();
    check_eq("postrst_ptr_m0", 32'(arb_gnt_o), 32'd1);
    drop_all(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
